grey_decoder_checker_nbit: RTL

- Registered Gray-to-binary decoder with sequence checking. It sits directly downstream of grey_encoder_nbit and consumes its o_grey stream, for example after a register or link hop.
- Each accepted Gray sample is decoded to binary.
- Each sample is checked against the previous accepted sample for a legal single step: up, down or hold.
- Illegal steps are flagged and counted, for link/encoder self-check in hardware.

---
 rtl/grey_decoder_checker_nbit.sv | 117 +++++++++++
 1 files changed

// File: rtl/grey_decoder_checker_nbit.sv
// Registered Gray-to-binary decoder that checks each accepted sample is a legal
// single step (up, down or hold) from the previous one and counts illegal steps.
module grey_decoder_checker_nbit #(
  parameter int n     = 3,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [n-1:0]     i_grey,
  output logic             o_valid,
  output logic [n-1:0]     o_bin,
  output logic             o_dir_up,
  output logic             o_hold,
  output logic             o_step_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [n-1:0]     BIN_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [n-1:0]     prev_bin_q, prev_bin_d;
  logic             valid_q, valid_d;
  logic [n-1:0]     bin_q, bin_d;
  logic             dir_up_q, dir_up_d;
  logic             hold_q, hold_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [n-1:0]     dec;
  logic [n-1:0]     prev_plus;
  logic [n-1:0]     prev_minus;
  logic             accept;

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec        = '0;
    dec[n-1]   = i_grey[n-1];
    for (int unsigned i = 1; i < n; i++) begin
      dec[n-1-i] = dec[n-i] ^ i_grey[n-1-i];
    end
  end

  assign prev_plus  = prev_bin_q + BIN_ONE;
  assign prev_minus = prev_bin_q - BIN_ONE;
  assign accept     = i_en & i_valid;

  always_comb begin
    state_d    = state_q;
    prev_bin_d = prev_bin_q;
    valid_d    = 1'b0;
    bin_d      = bin_q;
    dir_up_d   = dir_up_q;
    hold_d     = 1'b0;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (accept) begin
      valid_d    = 1'b1;
      bin_d      = dec;
      prev_bin_d = dec;
      state_d    = TRACK;
      if (state_q == TRACK) begin
        // Up is tested before down so that n = 1 resolves to an up step.
        if (dec == prev_bin_q) begin
          hold_d = 1'b1;
        end else if (dec == prev_plus) begin
          dir_up_d = 1'b1;
        end else if (dec == prev_minus) begin
          dir_up_d = 1'b0;
        end else begin
          step_err_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      prev_bin_q <= '0;
      valid_q    <= 1'b0;
      bin_q      <= '0;
      dir_up_q   <= 1'b0;
      hold_q     <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_bin_q <= prev_bin_d;
      valid_q    <= valid_d;
      bin_q      <= bin_d;
      dir_up_q   <= dir_up_d;
      hold_q     <= hold_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_bin      = bin_q;
  assign o_dir_up   = dir_up_q;
  assign o_hold     = hold_q;
  assign o_step_err = step_err_q;
  assign o_err_cnt  = err_cnt_q;

endmodule
